// File: rtl/fp_unpack_if.sv
// Operand-in / unpacked-operand-out handshake bundle for the FP unpack stage.
interface fp_unpack_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ftype;
    logic [63:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ftype;
    logic        out_sign;
    logic [12:0] out_exp;
    logic [52:0] out_mant;
    logic [2:0]  out_class;
    logic        out_invalid;

    modport master (
        output in_valid, in_ftype, in_value, out_ready,
        input  in_ready, out_valid, out_ftype, out_sign, out_exp, out_mant,
               out_class, out_invalid
    );

    modport slave (
        input  in_valid, in_ftype, in_value, out_ready,
        output in_ready, out_valid, out_ftype, out_sign, out_exp, out_mant,
               out_class, out_invalid
    );
endinterface

// File: rtl/fp_unpack.sv
// Unpacks a half/single/double operand into sign, unbiased exponent and a
// normalized 53-bit mantissa; subnormals are normalized over several cycles.
module fp_unpack #(
    parameter int unsigned NORM_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    fp_unpack_if.slave  bus
);
    localparam int unsigned MANT_W = 53;
    localparam int unsigned EXP_W  = 13;
    localparam logic [5:0]  NS     = 6'(NORM_SHIFT);

    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_NORM = 3'd1;
    localparam logic [2:0] CLS_SUB  = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_QNAN = 3'd4;
    localparam logic [2:0] CLS_SNAN = 3'd5;

    typedef enum logic [1:0] {IDLE, NORM, OUT} state_t;

    state_t              state_q;
    logic                valid_q;
    logic [1:0]          ftype_q;
    logic                sign_q;
    logic [EXP_W-1:0]    exp_q;
    logic [MANT_W-1:0]   mant_q;
    logic [2:0]          class_q;
    logic                inv_q;

    logic                in_ready_c;
    logic                accept_c;

    function automatic logic [5:0] lzc(input logic [MANT_W-1:0] m);
        logic [5:0] n;
        logic       hit;
        n   = '0;
        hit = 1'b0;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            if (!hit) begin
                if (m[i]) hit = 1'b1;
                else      n   = n + 6'd1;
            end
        end
        return n;
    endfunction

    assign in_ready_c = (state_q == IDLE) || (state_q == OUT && bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;

    // Field extraction and classification of the incoming operand
    logic [10:0]       e_raw_c;
    logic [10:0]       e_max_c;
    logic [51:0]       f_al_c;
    logic [EXP_W-1:0]  bias_c;
    logic              sign_in_c;
    logic [EXP_W-1:0]  dec_exp_c;
    logic [MANT_W-1:0] dec_mant_c;
    logic [2:0]        dec_class_c;
    logic              dec_sign_c;
    logic              dec_inv_c;
    state_t            dec_next_c;

    always_comb begin
        e_raw_c     = 11'(bus.in_value[62:52]);
        e_max_c     = 11'h7FF;
        f_al_c      = bus.in_value[51:0];
        bias_c      = 13'd1023;
        sign_in_c   = bus.in_value[63];
        dec_exp_c   = '0;
        dec_mant_c  = '0;
        dec_class_c = CLS_ZERO;
        dec_sign_c  = 1'b0;
        dec_inv_c   = 1'b0;
        dec_next_c  = OUT;

        case (bus.in_ftype)
            2'd0: begin
                e_raw_c   = 11'(bus.in_value[14:10]);
                e_max_c   = 11'h1F;
                f_al_c    = {bus.in_value[9:0], 42'b0};
                bias_c    = 13'd15;
                sign_in_c = bus.in_value[15];
            end
            2'd1: begin
                e_raw_c   = 11'(bus.in_value[30:23]);
                e_max_c   = 11'hFF;
                f_al_c    = {bus.in_value[22:0], 29'b0};
                bias_c    = 13'd127;
                sign_in_c = bus.in_value[31];
            end
            default: ;
        endcase

        if (bus.in_ftype == 2'd3) begin
            dec_exp_c   = 13'd1024;
            dec_mant_c  = 53'h18000000000000;
            dec_class_c = CLS_QNAN;
            dec_inv_c   = 1'b1;
        end else begin
            dec_sign_c = sign_in_c;
            if (e_raw_c == 11'd0 && f_al_c == '0) begin
                dec_class_c = CLS_ZERO;
            end else if (e_raw_c == 11'd0) begin
                dec_exp_c   = 13'd1 - bias_c;
                dec_mant_c  = {1'b0, f_al_c};
                dec_class_c = CLS_SUB;
                dec_next_c  = NORM;
            end else begin
                dec_exp_c  = 13'(e_raw_c) - bias_c;
                dec_mant_c = {1'b1, f_al_c};
                if (e_raw_c != e_max_c)  dec_class_c = CLS_NORM;
                else if (f_al_c == '0)   dec_class_c = CLS_INF;
                else if (f_al_c[51])     dec_class_c = CLS_QNAN;
                else                     dec_class_c = CLS_SNAN;
            end
        end
    end

    // One bounded normalization step for the subnormal path
    logic [5:0]        lz_c;
    logic [5:0]        sh_c;
    logic [MANT_W-1:0] mant_sh_c;
    logic [EXP_W-1:0]  exp_sh_c;

    always_comb begin
        lz_c      = lzc(mant_q);
        sh_c      = (lz_c > NS) ? NS : lz_c;
        mant_sh_c = mant_q << sh_c;
        exp_sh_c  = exp_q - 13'(sh_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ftype_q <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            class_q <= CLS_ZERO;
            inv_q   <= 1'b0;
        end else if (accept_c) begin
            state_q <= dec_next_c;
            valid_q <= (dec_next_c == OUT);
            ftype_q <= bus.in_ftype;
            sign_q  <= dec_sign_c;
            exp_q   <= dec_exp_c;
            mant_q  <= dec_mant_c;
            class_q <= dec_class_c;
            inv_q   <= dec_inv_c;
        end else begin
            case (state_q)
                NORM: begin
                    mant_q <= mant_sh_c;
                    exp_q  <= exp_sh_c;
                    if (mant_sh_c[MANT_W-1]) begin
                        state_q <= OUT;
                        valid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = valid_q;
    assign bus.out_ftype   = ftype_q;
    assign bus.out_sign    = sign_q;
    assign bus.out_exp     = exp_q;
    assign bus.out_mant    = mant_q;
    assign bus.out_class   = class_q;
    assign bus.out_invalid = inv_q;
endmodule

// File: tb/tb_fp_unpack.sv
// Directed scoreboard bench for fp_unpack (NORM_SHIFT=4 main DUT, NORM_SHIFT=1 secondary).
module tb_fp_unpack;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ftype;
        logic        sign;
        logic [12:0] exp;
        logic [52:0] mant;
        logic [2:0]  cls;
        logic        inv;
    } exp_t;

    fp_unpack_if bus0();
    fp_unpack_if bus1();

    fp_unpack #(.NORM_SHIFT(4)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus0));
    fp_unpack #(.NORM_SHIFT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    function automatic exp_t mk(input logic [1:0] ft, input logic s, input logic [12:0] e,
                                input logic [52:0] m, input logic [2:0] c, input logic inv);
        exp_t r;
        r.ftype = ft; r.sign = s; r.exp = e; r.mant = m; r.cls = c; r.inv = inv;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present an operand at a negedge and return at the negedge after it is accepted
    task automatic send(input logic [1:0] ft, input logic [63:0] v, input exp_t e);
        int n;
        n = 0;
        sb.push_back(e);
        bus0.in_valid = 1'b1;
        bus0.in_ftype = ft;
        bus0.in_value = v;
        while (!bus0.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 64'(n < 50), 64'd1);
        @(negedge clk);
        bus0.in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input int lat_exp);
        int   lat;
        exp_t e;
        lat = 1;
        while (!bus0.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(lat_exp));
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_ftype"}, 64'(bus0.out_ftype),   64'(e.ftype));
            chk({tag, "_sign"},  64'(bus0.out_sign),    64'(e.sign));
            chk({tag, "_exp"},   64'(bus0.out_exp),     64'(e.exp));
            chk({tag, "_mant"},  64'(bus0.out_mant),    64'(e.mant));
            chk({tag, "_class"}, 64'(bus0.out_class),   64'(e.cls));
            chk({tag, "_inv"},   64'(bus0.out_invalid), 64'(e.inv));
        end
    endtask

    localparam logic [52:0] M_ONE = 53'h10000000000000;

    initial begin
        exp_t e1;
        exp_t e2;
        int   cnt;
        int   lat;

        bus0.in_valid = 1'b0; bus0.in_ftype = '0; bus0.in_value = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_ftype = '0; bus1.in_value = '0; bus1.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready",  64'(bus0.in_ready),    64'd1);
        chk("rst_out_valid", 64'(bus0.out_valid),   64'd0);
        chk("rst_mant",      64'(bus0.out_mant),    64'd0);
        chk("rst_exp",       64'(bus0.out_exp),     64'd0);
        chk("rst_class",     64'(bus0.out_class),   64'd0);
        chk("rst_inv",       64'(bus0.out_invalid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send(2'd2, 64'h3FF0000000000000, mk(2'd2, 1'b0, 13'd0, M_ONE, 3'd1, 1'b0));
        recv("d_one", 1);
        send(2'd0, 64'h0000000000000001, mk(2'd0, 1'b0, 13'h1FE8, M_ONE, 3'd2, 1'b0));
        recv("h_submin", 4);
        send(2'd2, 64'h0000000000000001, mk(2'd2, 1'b0, 13'h1BCE, M_ONE, 3'd2, 1'b0));
        recv("d_submin", 14);
        send(2'd0, 64'h0000000000000200, mk(2'd0, 1'b0, 13'h1FF1, M_ONE, 3'd2, 1'b0));
        recv("h_submax", 2);
        send(2'd0, 64'h0000000000000400, mk(2'd0, 1'b0, 13'h1FF2, M_ONE, 3'd1, 1'b0));
        recv("h_normmin", 1);
        send(2'd1, 64'h000000007FA00000, mk(2'd1, 1'b0, 13'd128, 53'h14000000000000, 3'd5, 1'b0));
        recv("s_snan", 1);
        send(2'd1, 64'h000000007FC00000, mk(2'd1, 1'b0, 13'd128, 53'h18000000000000, 3'd4, 1'b0));
        recv("s_qnan", 1);
        send(2'd1, 64'h00000000FF800000, mk(2'd1, 1'b1, 13'd128, M_ONE, 3'd3, 1'b0));
        recv("s_ninf", 1);
        send(2'd3, 64'hFFFFFFFFFFFFFFFF, mk(2'd3, 1'b0, 13'd1024, 53'h18000000000000, 3'd4, 1'b1));
        recv("illegal", 1);
        send(2'd0, 64'h0000000000008000, mk(2'd0, 1'b1, 13'd0, 53'd0, 3'd0, 1'b0));
        recv("h_nzero", 1);
        send(2'd1, 64'hDEADBEEF3F800000, mk(2'd1, 1'b0, 13'd0, M_ONE, 3'd1, 1'b0));
        recv("s_upper", 1);

        // Output stall followed by a same-edge reload
        bus0.out_ready = 1'b0;
        e1 = mk(2'd1, 1'b0, 13'd0, M_ONE, 3'd1, 1'b0);
        send(2'd1, 64'h000000003F800000, e1);
        recv("stall0", 1);
        bus0.in_valid = 1'b1;
        bus0.in_ftype = 2'd0;
        bus0.in_value = 64'h0000000000003C00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(bus0.out_valid), 64'd1);
            chk("stall_ready", 64'(bus0.in_ready),  64'd0);
            chk("stall_ftype", 64'(bus0.out_ftype), 64'(e1.ftype));
            chk("stall_mant",  64'(bus0.out_mant),  64'(e1.mant));
        end
        e2 = mk(2'd0, 1'b0, 13'd0, M_ONE, 3'd1, 1'b0);
        sb.push_back(e2);
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        recv("b2b", 1);

        // Reset while normalizing
        send(2'd2, 64'h0000000000000001, mk(2'd2, 1'b0, 13'h1BCE, M_ONE, 3'd2, 1'b0));
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus0.out_valid), 64'd0);
        chk("midrst_ready", 64'(bus0.in_ready),  64'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus0.out_valid) cnt++;
        end
        chk("no_stale", 64'(cnt), 64'd0);
        send(2'd2, 64'hC000000000000000, mk(2'd2, 1'b1, 13'd1, M_ONE, 3'd1, 1'b0));
        recv("post_rst", 1);

        // Single-bit-per-cycle normalizer
        bus1.in_valid = 1'b1;
        bus1.in_ftype = 2'd2;
        bus1.in_value = 64'h0000000000000001;
        chk("ns1_ready", 64'(bus1.in_ready), 64'd1);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        lat = 1;
        while (!bus1.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("ns1_lat",   64'(lat),             64'd53);
        chk("ns1_exp",   64'(bus1.out_exp),    64'h1BCE);
        chk("ns1_mant",  64'(bus1.out_mant),   64'(M_ONE));
        chk("ns1_class", 64'(bus1.out_class),  64'd2);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
